// File: rtl/fisc_pkg.sv
// Shared definitions for the operand-fetch stage: widths, special register indices and FSM states.
package fisc_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned RIDX_W = 6;
  localparam int unsigned TAG_W  = 32;

  localparam logic [RIDX_W-1:0] REG_PC   = 6'd32;
  localparam logic [RIDX_W-1:0] REG_PFLA = 6'd45;
  localparam logic [RIDX_W-1:0] REG_LAST = REG_PFLA;

  typedef enum logic [1:0] {
    StIdle,
    StRdA,
    StRdB,
    StOut
  } of_state_t;

  function automatic logic idx_legal(input logic [RIDX_W-1:0] idx);
    return idx <= REG_LAST;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side, register-file-side and execute-side signals of the operand-fetch stage.
interface operand_fetch_if;
  import fisc_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [RIDX_W-1:0] in_rs1;
  logic [RIDX_W-1:0] in_rs2;
  logic              in_use_rs2;
  logic [DATA_W-1:0] in_imm;
  logic [TAG_W-1:0]  in_tag;
  logic              wb_busy;
  logic [RIDX_W-1:0] rd_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op_a;
  logic [DATA_W-1:0] out_op_b;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport slave (
    input  flush, in_valid, in_rs1, in_rs2, in_use_rs2, in_imm, in_tag,
    input  wb_busy, dout_reg, out_ready,
    output in_ready, rd_reg, out_valid, out_op_a, out_op_b, out_tag, out_err
  );

  modport master (
    output flush, in_valid, in_rs1, in_rs2, in_use_rs2, in_imm, in_tag,
    output wb_busy, dout_reg, out_ready,
    input  in_ready, rd_reg, out_valid, out_op_a, out_op_b, out_tag, out_err
  );

endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads up to two sources through the single register-file read port,
// stalling while the register file writes, and hands op_a/op_b/tag to execute.
module operand_fetch
  import fisc_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);

  of_state_t         r_state;
  logic [RIDX_W-1:0] r_rs1;
  logic [RIDX_W-1:0] r_rs2;
  logic [RIDX_W-1:0] r_rd_last;
  logic              r_use_rs2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [TAG_W-1:0]  r_tag;
  logic              r_err;

  logic [RIDX_W-1:0] w_rd_idx;
  logic              w_rd_ok;
  logic [DATA_W-1:0] w_rd_data;

  // Outside the read states the port keeps showing the last index read.
  always_comb begin
    w_rd_idx = r_rd_last;
    case (r_state)
      StRdA:   w_rd_idx = r_rs1;
      StRdB:   w_rd_idx = r_rs2;
      default: w_rd_idx = r_rd_last;
    endcase
  end

  assign w_rd_ok   = idx_legal(w_rd_idx);
  assign w_rd_data = w_rd_ok ? bus.dout_reg : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd_last <= '0;
      r_use_rs2 <= 1'b0;
      r_imm     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_tag     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == StRdA || r_state == StRdB) r_rd_last <= w_rd_idx;
      if (bus.flush) begin
        r_state <= StIdle;
      end else begin
        case (r_state)
          StIdle: begin
            if (bus.in_valid) begin
              r_rs1     <= bus.in_rs1;
              r_rs2     <= bus.in_rs2;
              r_use_rs2 <= bus.in_use_rs2;
              r_imm     <= bus.in_imm;
              r_tag     <= bus.in_tag;
              r_err     <= 1'b0;
              r_state   <= StRdA;
            end
          end
          StRdA: begin
            if (!bus.wb_busy) begin
              r_op_a <= w_rd_data;
              r_err  <= r_err | ~w_rd_ok;
              if (r_use_rs2) begin
                r_state <= StRdB;
              end else begin
                r_op_b  <= r_imm;
                r_state <= StOut;
              end
            end
          end
          StRdB: begin
            if (!bus.wb_busy) begin
              r_op_b  <= w_rd_data;
              r_err   <= r_err | ~w_rd_ok;
              r_state <= StOut;
            end
          end
          StOut: begin
            if (bus.out_ready) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StOut);
  assign bus.rd_reg    = w_rd_idx;
  assign bus.out_op_a  = r_op_a;
  assign bus.out_op_b  = r_op_b;
  assign bus.out_tag   = r_tag;
  assign bus.out_err   = r_err;

endmodule
